// File: rtl/glyph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glyph_pkg : shared constants, scan state encoding and a width helper for   |
// |             the glyph tile capture/scanout block.                          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package glyph_pkg;

  localparam int         c_TILE_W    = 32;
  localparam int         c_TILE_H    = 32;
  localparam logic [2:0] c_FG_COLOUR = 3'b111;
  localparam logic [2:0] c_BG_COLOUR = 3'b000;
  localparam int         c_LOCAL_XW  = 5;
  localparam int         c_LOCAL_YW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Index width that stays legal for a degenerate 1-wide dimension.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_tile_scanout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_raster_counter : row-major x/y index pair with advance and last flag. |
// | Revision            : 1.0 - initial release                                |
// +----------------------------------------------------------------------------+
module tile_raster_counter #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32,
  parameter int XW     = 5,
  parameter int YW     = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_restart,
  input  logic          i_advance,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  localparam logic [XW-1:0] c_X_MAX = XW'(TILE_W - 1);
  localparam logic [YW-1:0] c_Y_MAX = YW'(TILE_H - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk) begin
    if (!resetn || i_restart) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == c_X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == c_Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

endmodule
`default_nettype wire

// File: rtl/glyph_tile_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glyph_tile_scanout : captures drawer pixel writes into a 1-bit tile bitmap |
// |   and replays it as a valid/ready (x,y,colour) stream. Define              |
// |   GLYPH_SKIP_BLANK_EN to present only set pixels during readback.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module glyph_tile_scanout
  import glyph_pkg::*;
#(
  parameter int         TILE_W    = c_TILE_W,
  parameter int         TILE_H    = c_TILE_H,
  parameter logic [2:0] FG_COLOUR = c_FG_COLOUR,
  parameter logic [2:0] BG_COLOUR = c_BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       cap_en,
  input  logic [7:0] cap_x,
  input  logic [6:0] cap_y,
  input  logic [7:0] org_x,
  input  logic [6:0] org_y,
  input  logic       scan_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       busy,
  output logic       scan_done
);

  localparam int c_XW   = idxWidth(TILE_W);
  localparam int c_YW   = idxWidth(TILE_H);
  localparam int c_NPIX = TILE_W * TILE_H;
  localparam int c_IW   = idxWidth(c_NPIX);
`ifdef GLYPH_SKIP_BLANK_EN
  localparam bit c_SKIP_BLANK = 1'b1;
`else
  localparam bit c_SKIP_BLANK = 1'b0;
`endif

  scan_state_t       r_state;
  logic [c_NPIX-1:0] r_bitmap;
  logic [7:0]        r_orgX;
  logic [6:0]        r_orgY;

  logic [c_XW-1:0]   w_scanX;
  logic [c_YW-1:0]   w_scanY;
  logic              w_scanLast;
  logic [8:0]        w_locX;
  logic [8:0]        w_locY;
  logic              w_capHit;
  logic [c_IW-1:0]   w_capIdx;
  logic [c_IW-1:0]   w_scanIdx;
  logic              w_pixSet;
  logic              w_inScan;
  logic              w_present;
  logic              w_step;
  logic              w_start;

  // 9-bit difference: a borrow shows up as a large value, but the >= guards make that explicit.
  assign w_locX   = {1'b0, cap_x} - {1'b0, org_x};
  assign w_locY   = {2'b0, cap_y} - {2'b0, org_y};
  assign w_capHit = cap_en && (cap_x >= org_x) && (cap_y >= org_y)
                    && (32'(w_locX) < TILE_W) && (32'(w_locY) < TILE_H);
  assign w_capIdx = c_IW'(32'(w_locY) * TILE_W + 32'(w_locX));

  assign w_scanIdx = c_IW'(32'(w_scanY) * TILE_W + 32'(w_scanX));
  assign w_pixSet  = r_bitmap[w_scanIdx];
  assign w_inScan  = (r_state == SCAN);
  assign w_present = c_SKIP_BLANK ? w_pixSet : 1'b1;
  // Blank pixels in skip mode advance without waiting for the consumer.
  assign w_step    = w_inScan && (!w_present || out_ready);
  assign w_start   = (r_state == IDLE) && scan_start;

  tile_raster_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .XW     (c_XW),
    .YW     (c_YW)
  ) u_counter (
    .clk       (clk),
    .resetn    (resetn),
    .i_restart (w_start),
    .i_advance (w_step),
    .o_x       (w_scanX),
    .o_y       (w_scanY),
    .o_last    (w_scanLast)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_bitmap <= '0;
      r_orgX   <= '0;
      r_orgY   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear)         r_bitmap           <= '0;
          else if (w_capHit) r_bitmap[w_capIdx] <= 1'b1;
          if (scan_start) begin
            r_orgX  <= org_x;
            r_orgY  <= org_y;
            r_state <= SCAN;
          end
        end
        SCAN:    if (w_step && w_scanLast) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = w_inScan && w_present;
  assign busy       = w_inScan;
  assign scan_done  = (r_state == DONE);
  assign out_x      = out_valid ? (r_orgX + 8'(w_scanX)) : '0;
  assign out_y      = out_valid ? (r_orgY + 7'(w_scanY)) : '0;
  assign out_colour = out_valid ? (w_pixSet ? FG_COLOUR : BG_COLOUR) : '0;

endmodule
`default_nettype wire

// File: tb/tb_glyph_tile_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_glyph_tile_scanout : directed + randomized bench with a bitmap model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_glyph_tile_scanout;

  localparam int         W  = 32;
  localparam int         H  = 32;
  localparam int         N  = W * H;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;
`ifdef GLYPH_SKIP_BLANK_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn, clear, cap_en, scan_start, out_ready;
  logic [7:0] cap_x, org_x, out_x;
  logic [6:0] cap_y, org_y, out_y;
  logic [2:0] out_colour;
  logic       out_valid, busy, scan_done;

  int checks = 0;
  int errors = 0;
  bit model [H][W];

  always #5 clk = ~clk;

  glyph_tile_scanout dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .cap_en     (cap_en),
    .cap_x      (cap_x),
    .cap_y      (cap_y),
    .org_x      (org_x),
    .org_y      (org_y),
    .scan_start (scan_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = 1'b0;
  endtask

  task automatic modelCapture(input int cx, input int cy, input int ox, input int oy);
    int lx, ly;
    lx = cx - ox;
    ly = cy - oy;
    if (lx >= 0 && lx < W && ly >= 0 && ly < H) model[ly][lx] = 1'b1;
  endtask

  task automatic capture(input int cx, input int cy);
    cap_x  = 8'(cx);
    cap_y  = 7'(cy);
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
    modelCapture(cx, cy, int'(org_x), int'(org_y));
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelClear();
  endtask

  // Runs one readback; random ready, stray scan_start and org changes exercise latching/stalls.
  task automatic runScan(input string tag, input bit randReady, input int stopAfter,
                         input bit withCap, input int cx, input int cy);
    pix_t       exp[$];
    pix_t       prev, got;
    bit         prevStall;
    bit         doneSeen;
    int         n, nXfer, nExp;
    logic [7:0] ox;
    logic [6:0] oy;
    ox = org_x;
    oy = org_y;
    if (withCap) begin
      cap_x  = 8'(cx);
      cap_y  = 7'(cy);
      cap_en = 1'b1;
      modelCapture(cx, cy, int'(ox), int'(oy));
    end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (!SKIP || model[y][x])
          exp.push_back('{x: 8'((int'(ox) + x) % 256), y: 7'((int'(oy) + y) % 128),
                          c: model[y][x] ? FG : BG});
    nExp       = exp.size();
    out_ready  = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    cap_en     = 1'b0;
    if (!SKIP) check($sformatf("%s first_valid", tag), 32'(out_valid), 32'd1);
    prevStall = 1'b0;
    doneSeen  = 1'b0;
    nXfer     = 0;
    prev      = '0;
    for (n = 1; n <= 3 * N; n++) begin
      if (prevStall) begin
        check($sformatf("%s stall_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s stall_hold", tag), 32'({out_x, out_y, out_colour}), 32'(prev));
      end
      if (scan_done) begin
        doneSeen = 1'b1;
        break;
      end
      if (stopAfter > 0 && nXfer == stopAfter) break;
      out_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      scan_start = ($urandom_range(0, 15) == 0);
      org_x      = 8'($urandom);
      org_y      = 7'($urandom);
      got        = '{x: out_x, y: out_y, c: out_colour};
      if (out_valid && out_ready) begin
        if (exp.size() == 0) check($sformatf("%s extra_pixel", tag), 32'd1, 32'd0);
        else check($sformatf("%s pixel%0d", tag, nXfer), 32'(got), 32'(exp.pop_front()));
        nXfer++;
      end
      prevStall = out_valid && !out_ready;
      prev      = got;
      tick();
    end
    scan_start = 1'b0;
    org_x      = ox;
    org_y      = oy;
    if (stopAfter == 0) begin
      check($sformatf("%s done_seen", tag), 32'(doneSeen), 32'd1);
      check($sformatf("%s transfers", tag), 32'(nXfer), 32'(nExp));
      if (!randReady) check($sformatf("%s done_latency", tag), 32'(n), 32'(1 + N));
      out_ready = 1'b1;
      tick();
      check($sformatf("%s done_once", tag), 32'(scan_done), 32'd0);
      check($sformatf("%s idle_busy", tag), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    clear      = 1'b0;
    cap_en     = 1'b0;
    scan_start = 1'b0;
    out_ready  = 1'b1;
    cap_x      = '0;
    cap_y      = '0;
    org_x      = 8'd40;
    org_y      = 7'd20;
    modelClear();

    // T1: reset state and empty readback
    tick();
    tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst scan_done", 32'(scan_done), 32'd0);
    check("rst out_xyc", 32'({out_x, out_y, out_colour}), 32'd0);
    resetn = 1'b1;
    tick();
    runScan("T1", 1'b0, 0, 1'b0, 0, 0);

    // T2: two captured pixels
    doClear();
    capture(51, 27);
    capture(58, 41);
    runScan("T2", 1'b0, 0, 1'b0, 0, 0);

    // T3: clipped captures at every edge
    doClear();
    capture(39, 20);
    capture(72, 20);
    capture(40, 52);
    capture(40, 19);
    capture(71, 51);
    runScan("T3", 1'b0, 0, 1'b0, 0, 0);

    // T4: random captures near the tile, random backpressure
    doClear();
    for (int i = 0; i < 24; i++) capture(36 + $urandom_range(0, 40), 16 + $urandom_range(0, 40));
    runScan("T4", 1'b1, 0, 1'b0, 0, 0);
    org_x = 8'd240;
    org_y = 7'd110;
    doClear();
    for (int i = 0; i < 12; i++) capture(240 + $urandom_range(0, 15), 110 + $urandom_range(0, 17));
    runScan("T4wrap", 1'b1, 0, 1'b0, 0, 0);
    org_x = 8'd40;
    org_y = 7'd20;

    // T5: clear wins over capture; capture in the scan_start cycle is included
    doClear();
    capture(50, 30);
    cap_x  = 8'd52;
    cap_y  = 7'd31;
    cap_en = 1'b1;
    clear  = 1'b1;
    tick();
    cap_en = 1'b0;
    clear  = 1'b0;
    modelClear();
    runScan("T5", 1'b0, 0, 1'b1, 45, 25);

    // T6: reset mid-scan
    capture(60, 40);
    runScan("T6a", 1'b0, 300, 1'b0, 0, 0);
    resetn = 1'b0;
    tick();
    check("T6 rst_valid", 32'(out_valid), 32'd0);
    check("T6 rst_done", 32'(scan_done), 32'd0);
    resetn = 1'b1;
    modelClear();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("T6 no_done", 32'(scan_done), 32'd0);
      check("T6 idle_busy", 32'(busy), 32'd0);
    end
    runScan("T6b", 1'b1, 0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
